// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the load/store unit memory initiator:
// func3 load/store codes, FSM state encoding, access size decode and
// byte-lane helpers used by both the top and the load aligner.
package lsu_mem_initiator_pkg;

    // Load func3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store func3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SizeByte,
        SizeHalf,
        SizeWord
    } lsu_size_t;

    // Unlisted func3 encodings fall through to a full-word access.
    function automatic lsu_size_t access_size(input logic store, input logic [2:0] func3);
        lsu_size_t size;
        size = SizeWord;
        if (store) begin
            case (func3)
                F3_SB:   size = SizeByte;
                F3_SH:   size = SizeHalf;
                F3_SW:   size = SizeWord;
                default: size = SizeWord;
            endcase
        end else begin
            case (func3)
                F3_LB, F3_LBU: size = SizeByte;
                F3_LH, F3_LHU: size = SizeHalf;
                F3_LW:         size = SizeWord;
                default:       size = SizeWord;
            endcase
        end
        return size;
    endfunction

    // Halves use only lane[1] and words no lane bits, so misaligned
    // addresses collapse onto the containing aligned unit.
    function automatic logic [3:0] byte_enable(input lsu_size_t size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SizeByte: be = 4'b0001 << lane;
            SizeHalf: be = 4'b0011 << {lane[1], 1'b0};
            default:  be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input lsu_size_t size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SizeByte: lanes = {4{wdata[7:0]}};
            SizeHalf: lanes = {2{wdata[15:0]}};
            default:  lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_load_align.sv
// Combinational load aligner: picks the byte or half addressed by the
// low address bits out of the returned word and sign/zero extends it.
module lsu_mem_initiator_load_align
    import lsu_mem_initiator_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension chosen by func3.
    always_comb begin
        byte_sel = 8'h00;
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (func3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h000000, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0000, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit, initiator side of the data-memory interface.
// Accepts one load/store, issues a registered request, waits for grant
// and response, then pulses wb_valid with extended load data.
// Accesses that see no response within TIMEOUT cycles abort with err.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// rejected with an err pulse instead of being forced aligned.
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall,
    output logic        err
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    lsu_state_t  state_q;
    logic [7:0]  cnt_q;
    logic        store_q;
    logic [2:0]  func3_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;

    lsu_size_t   req_size;
    logic        misaligned;
    logic        timeout;
    logic [31:0] load_data;

    assign req_size = access_size(req_store, req_func3);
    assign timeout  = (cnt_q == TimeoutLast);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((req_size == SizeHalf) && req_addr[0]) ||
                        ((req_size == SizeWord) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    lsu_mem_initiator_load_align u_load_align (
        .func3 (func3_q),
        .lane  (lane_q),
        .rdata (mem_rdata),
        .data  (load_data)
    );

    // Stall while an access is in flight; released in the DONE cycle.
    always_comb begin
        stall = (state_q == REQ) || (state_q == WAIT) || (req_valid && req_ready);
    end

    // Access FSM with registered memory-side and writeback outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            store_q   <= 1'b0;
            func3_q   <= 3'b000;
            lane_q    <= 2'b00;
            rd_q      <= 5'd0;
            req_ready <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'h0;
            err       <= 1'b0;
        end else begin
            // Single-cycle pulses.
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            err      <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        store_q <= req_store;
                        func3_q <= req_func3;
                        lane_q  <= req_addr[1:0];
                        rd_q    <= req_rd;
                        cnt_q   <= 8'd0;
                        if (misaligned) begin
                            err <= 1'b1;
                        end else begin
                            state_q   <= REQ;
                            req_ready <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_be    <= byte_enable(req_size, req_addr[1:0]);
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_store ? store_lanes(req_size, req_wdata) : 32'h0;
                        end
                    end
                end
                REQ, WAIT: begin
                    // A response completes the access even on the last counted cycle.
                    if (mem_rvalid && ((state_q == WAIT) || mem_gnt)) begin
                        state_q  <= DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'b0000;
                        wb_valid <= 1'b1;
                        wb_we    <= !store_q;
                        wb_rd    <= rd_q;
                        wb_data  <= store_q ? 32'h0 : load_data;
                    end else if (timeout) begin
                        state_q   <= IDLE;
                        req_ready <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= 4'b0000;
                        err       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if ((state_q == REQ) && mem_gnt) begin
                            state_q <= WAIT;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            mem_be  <= 4'b0000;
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a writeback scoreboard.
module tb_lsu_mem_initiator;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam int TimeoutCycles = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_func3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, err;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;
    wb_exp_t sb[$];

    lsu_mem_initiator dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .stall      (stall),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_store = store;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        #1;
        chk("stall_accept", {31'b0, stall}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_wb(input string name);
        wb_exp_t e;
        int n = 0;
        while (!wb_valid && n < 8) begin
            step();
            n++;
        end
        chk({name, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
        if (wb_valid && sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, "_wb_we"}, {31'b0, wb_we}, {31'b0, e.we});
            chk({name, "_wb_rd"}, {27'b0, wb_rd}, {27'b0, e.rd});
            chk({name, "_wb_data"}, wb_data, e.data);
        end
    endtask

    // One complete access with a responder that grants after gnt_delay cycles.
    task automatic access(input string name, input logic store, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata,
                          input int gnt_delay, input bit same_cycle,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_wb);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        sb.push_back('{we: !store, rd: rd, data: exp_wb});
        issue(store, f3, addr, wdata, rd);
        for (int i = 0; i <= gnt_delay; i++) begin
            chk({name, "_mem_req"}, {31'b0, mem_req}, 32'd1);
            chk({name, "_mem_we"}, {31'b0, mem_we}, {31'b0, store});
            chk({name, "_mem_be"}, {28'b0, mem_be}, {28'b0, exp_be});
            chk({name, "_mem_addr"}, mem_addr, exp_addr);
            if (store) chk({name, "_mem_wdata"}, mem_wdata, exp_wdata);
            chk({name, "_stall"}, {31'b0, stall}, 32'd1);
            if (i < gnt_delay) step();
        end
        mem_gnt = 1'b1;
        if (same_cycle) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
        end
        step();
        mem_gnt = 1'b0;
        if (!same_cycle) begin
            chk({name, "_mem_req_drop"}, {31'b0, mem_req}, 32'd0);
            chk({name, "_stall_wait"}, {31'b0, stall}, 32'd1);
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            step();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        wait_wb(name);
        chk({name, "_stall_done"}, {31'b0, stall}, 32'd0);
        step();
        chk({name, "_wb_pulse"}, {31'b0, wb_valid}, 32'd0);
        chk({name, "_ready_after"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int  n;
        bit  saw_wb;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_func3  = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Aligned word load.
        access("lw", 1'b0, LW, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 0, 1'b0,
               4'b1111, 32'h0, 32'hDEADBEEF);
        // Byte loads from the top lane, signed and unsigned.
        access("lb", 1'b0, LB, 32'h103, 32'h0, 5'd6, 32'h80FF0000, 0, 1'b0,
               4'b1000, 32'h0, 32'hFFFFFF80);
        access("lbu", 1'b0, LBU, 32'h103, 32'h0, 5'd6, 32'h80FF0000, 0, 1'b0,
               4'b1000, 32'h0, 32'h00000080);
        // Half store with delayed grant; request must hold until granted.
        access("sh", 1'b1, SH, 32'h202, 32'h1234ABCD, 5'd7, 32'h0, 3, 1'b0,
               4'b1100, 32'hABCDABCD, 32'h0);
        // Grant and response in the same cycle.
        access("lh", 1'b0, LH, 32'h102, 32'h0, 5'd8, 32'h80011234, 0, 1'b1,
               4'b1100, 32'h0, 32'hFFFF8001);
        access("lhu", 1'b0, LHU, 32'h100, 32'h0, 5'd9, 32'h80011234, 1, 1'b0,
               4'b0011, 32'h0, 32'h00001234);
        access("sb", 1'b1, SB, 32'h101, 32'h000000A5, 5'd10, 32'h0, 0, 1'b0,
               4'b0010, 32'hA5A5A5A5, 32'h0);
        // Unlisted func3 behaves as a word load.
        access("f3_111", 1'b0, 3'b111, 32'h104, 32'h0, 5'd11, 32'h89ABCDEF, 0, 1'b0,
               4'b1111, 32'h0, 32'h89ABCDEF);

        // Timeout: granted, response never arrives.
        issue(1'b0, LW, 32'h300, 32'h0, 5'd12);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        n = 1;
        saw_wb = 1'b0;
        while (!err && n < 100) begin
            saw_wb = saw_wb | wb_valid;
            step();
            n++;
        end
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_cycle", n, TimeoutCycles);
        chk("to_no_wb", {31'b0, saw_wb | wb_valid}, 32'd0);
        chk("to_mem_req", {31'b0, mem_req}, 32'd0);
        step();
        chk("to_err_pulse", {31'b0, err}, 32'd0);
        chk("to_ready", {31'b0, req_ready}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        step();
        mem_rvalid = 1'b0;
        chk("to_late_rvalid", {31'b0, wb_valid}, 32'd0);
        step();
        chk("to_late_rvalid2", {31'b0, wb_valid}, 32'd0);
        chk("to_stall", {31'b0, stall}, 32'd0);

        // Asynchronous reset while waiting for the response.
        issue(1'b0, LW, 32'h400, 32'h0, 5'd13);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        reset = 1'b1;
        #1;
        chk("ar_mem_req", {31'b0, mem_req}, 32'd0);
        chk("ar_ready", {31'b0, req_ready}, 32'd1);
        chk("ar_stall", {31'b0, stall}, 32'd0);
        chk("ar_wb_rd", {27'b0, wb_rd}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        step();
        mem_rvalid = 1'b0;
        chk("ar_late_wb", {31'b0, wb_valid}, 32'd0);
        chk("ar_wb_data", wb_data, 32'd0);
        chk("ar_err", {31'b0, err}, 32'd0);
        step();
        chk("ar_late_wb2", {31'b0, wb_valid}, 32'd0);
        chk("ar_ready2", {31'b0, req_ready}, 32'd1);

        // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, LW, 32'h101, 32'h0, 5'd14);
        chk("mis_err", {31'b0, err}, 32'd1);
        chk("mis_mem_req", {31'b0, mem_req}, 32'd0);
        chk("mis_wb", {31'b0, wb_valid}, 32'd0);
        chk("mis_ready", {31'b0, req_ready}, 32'd1);
        step();
        chk("mis_err_pulse", {31'b0, err}, 32'd0);
        chk("mis_mem_req2", {31'b0, mem_req}, 32'd0);
        chk("mis_wb2", {31'b0, wb_valid}, 32'd0);
`else
        access("lw_mis", 1'b0, LW, 32'h101, 32'h0, 5'd14, 32'h11223344, 0, 1'b0,
               4'b1111, 32'h0, 32'h11223344);
        chk("mis_no_err", {31'b0, err}, 32'd0);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
